rom_port_arbiter: RTL and testbench



---
 rtl/rom_arb_pkg.sv | 10 +
 rtl/rom_arb_grant.sv | 28 ++
 rtl/rom_port_arbiter.sv | 70 +++++++
 tb/tb_rom_port_arbiter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: shared port/response types and the ROM window decode helper.
package rom_arb_pkg;
  typedef enum logic {PORT_I, PORT_D} rom_port_e;
  typedef struct packed {logic valid; logic err; logic [31:0] data;} rom_resp_t;
  function automatic logic rom_in_range(input logic [31:0] addr, input logic [31:0] base, input logic [31:0] bytes);
    logic [31:0] off;
    off = addr - base;
    return addr[1:0] == 2'b00 && addr >= base && off < bytes;
  endfunction
endpackage

// File: rtl/rom_arb_grant.sv
// rom_arb_grant: one-hot grant between I and D; round-robin when ROM_ARB_RR_EN is defined, else D over I.
module rom_arb_grant
  import rom_arb_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      elig_i,
  input  logic      elig_d,
  output logic      gnt_i,
  output logic      gnt_d,
  output rom_port_e ptr
);
`ifdef ROM_ARB_RR_EN
  // ptr holds the last granted port; a tie goes to the other one
  assign gnt_d = elig_d & (~elig_i | ptr == PORT_I);
  assign gnt_i = elig_i & ~gnt_d;
  always_ff @(posedge clk) begin
    if (rst) ptr <= PORT_I;
    else if (gnt_i | gnt_d) ptr <= gnt_d ? PORT_D : PORT_I;
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk | rst;
  assign gnt_d = elig_d;
  assign gnt_i = elig_i & ~elig_d;
  assign ptr = PORT_I;
`endif
endmodule

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares one combinational ROM between fetch (I) and load (D) ports; ROM_ARB_RR_EN selects round-robin.
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter logic [31:0] ROM_BASE  = 32'h0000_0000,
  parameter int unsigned ROM_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  output logic        i_req_ready,
  input  logic [31:0] i_req_addr,
  output logic        i_resp_valid,
  input  logic        i_resp_ready,
  output logic [31:0] i_resp_data,
  output logic        i_resp_err,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [31:0] d_req_addr,
  output logic        d_resp_valid,
  input  logic        d_resp_ready,
  output logic [31:0] d_resp_data,
  output logic        d_resp_err,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data
);
  rom_resp_t i_slot, d_slot, resp;
  logic elig_i, elig_d, gnt_i, gnt_d;
  logic [31:0] addr, off;
  rom_port_e unused_ptr;
  assign elig_i = i_req_valid & (~i_slot.valid | i_resp_ready);
  assign elig_d = d_req_valid & (~d_slot.valid | d_resp_ready);
  rom_arb_grant u_grant (
    .clk    (clk),
    .rst    (rst),
    .elig_i (elig_i),
    .elig_d (elig_d),
    .gnt_i  (gnt_i),
    .gnt_d  (gnt_d),
    .ptr    (unused_ptr)
  );
  always_comb begin
    addr = gnt_d ? d_req_addr : i_req_addr;
    off = addr - ROM_BASE;
    rom_addr = (gnt_i | gnt_d) ? (off & 32'hffff_fffc) : 32'h0;
    resp.valid = 1'b1;
    resp.err = ~rom_in_range(addr, ROM_BASE, 32'(ROM_BYTES));
    resp.data = resp.err ? 32'h0 : rom_data;
  end
  // a grant refills the slot even while it drains, giving back-to-back responses
  always_ff @(posedge clk) begin
    if (rst) begin
      i_slot <= '0;
      d_slot <= '0;
    end else begin
      if (gnt_i) i_slot <= resp;
      else if (i_resp_ready) i_slot.valid <= 1'b0;
      if (gnt_d) d_slot <= resp;
      else if (d_resp_ready) d_slot.valid <= 1'b0;
    end
  end
  assign i_req_ready  = gnt_i;
  assign d_req_ready  = gnt_d;
  assign i_resp_valid = i_slot.valid;
  assign i_resp_err   = i_slot.err;
  assign i_resp_data  = i_slot.data;
  assign d_resp_valid = d_slot.valid;
  assign d_resp_err   = d_slot.err;
  assign d_resp_data  = d_slot.data;
endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter: directed vector table plus multi-cycle sequences for rom_port_arbiter (honours ROM_ARB_RR_EN).
module tb_rom_port_arbiter;
  logic clk, rst;
  logic i_req_valid, i_req_ready, i_resp_valid, i_resp_ready, i_resp_err;
  logic d_req_valid, d_req_ready, d_resp_valid, d_resp_ready, d_resp_err;
  logic [31:0] i_req_addr, i_resp_data, d_req_addr, d_resp_data, rom_addr, rom_data;
  int n_tests = 0, n_fail = 0;

  rom_port_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_resp_valid(i_resp_valid), .i_resp_ready(i_resp_ready), .i_resp_data(i_resp_data), .i_resp_err(i_resp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_resp_valid(d_resp_valid), .d_resp_ready(d_resp_ready), .d_resp_data(d_resp_data), .d_resp_err(d_resp_err),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // boot ROM image: known words at a few addresses, a recognisable pattern elsewhere
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h00: return 32'h0000_1117;
      32'h04: return 32'h8e01_0113;
      32'h08: return 32'h0e00_0d13;
      32'hdc: return 32'h0000_8067;
      default: return {16'hc0de, a[15:0]};
    endcase
  endfunction
  assign rom_data = rom_word(rom_addr);

  typedef struct {
    logic iv; logic [31:0] ia; logic irr;
    logic dv; logic [31:0] da; logic drr;
    logic ei_rdy; logic ed_rdy; logic [31:0] erom;
    logic eiv; logic [31:0] eid; logic eie;
    logic edv; logic [31:0] edd; logic ede;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] ia, input logic irr,
                       input logic dv, input logic [31:0] da, input logic drr);
    i_req_valid = iv; i_req_addr = ia; i_resp_ready = irr;
    d_req_valid = dv; d_req_addr = da; d_resp_ready = drr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h4,   1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h4,   1'b1, 32'h8e010113, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[1] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0, 1'b0,        1'b0, 32'h0, 1'b0};
    vecs[2] = '{1'b1, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h00001117, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[3] = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h102, 1'b1, 1'b0, 1'b1, 32'h100, 1'b1, 32'h00001117, 1'b0, 1'b1, 32'h0, 1'b1};
    vecs[4] = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 1'b1, 32'h200, 1'b1, 32'h00001117, 1'b0, 1'b1, 32'h0, 1'b1};
    vecs[5] = '{1'b1, 32'h8,   1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h8,   1'b1, 32'h0e000d13, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[6] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'hfc,  1'b1, 1'b0, 1'b1, 32'hfc,  1'b0, 32'h0, 1'b0,        1'b1, 32'hc0de00fc, 1'b0};
    vecs[7] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0,        1'b1, 32'h0, 1'b1};
    vecs[8] = '{1'b1, 32'h3,   1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h0, 1'b1,        1'b0, 32'h0, 1'b0};

    do_reset();
    chk("rst i_req_ready", 32'(i_req_ready), 0);
    chk("rst d_req_ready", 32'(d_req_ready), 0);
    chk("rst i_resp_valid", 32'(i_resp_valid), 0);
    chk("rst d_resp_valid", 32'(d_resp_valid), 0);
    chk("rst i_resp_data", i_resp_data, 0);
    chk("rst d_resp_data", d_resp_data, 0);
    chk("rst i_resp_err", 32'(i_resp_err), 0);
    chk("rst d_resp_err", 32'(d_resp_err), 0);
    chk("rst rom_addr", rom_addr, 0);

    for (int v = 0; v < 9; v++) begin
      drive(vecs[v].iv, vecs[v].ia, vecs[v].irr, vecs[v].dv, vecs[v].da, vecs[v].drr);
      chk($sformatf("vec%0d i_req_ready", v), 32'(i_req_ready), 32'(vecs[v].ei_rdy));
      chk($sformatf("vec%0d d_req_ready", v), 32'(d_req_ready), 32'(vecs[v].ed_rdy));
      chk($sformatf("vec%0d rom_addr", v), rom_addr, vecs[v].erom);
      tick();
      chk($sformatf("vec%0d i_resp_valid", v), 32'(i_resp_valid), 32'(vecs[v].eiv));
      chk($sformatf("vec%0d d_resp_valid", v), 32'(d_resp_valid), 32'(vecs[v].edv));
      if (vecs[v].eiv) begin
        chk($sformatf("vec%0d i_resp_data", v), i_resp_data, vecs[v].eid);
        chk($sformatf("vec%0d i_resp_err", v), 32'(i_resp_err), 32'(vecs[v].eie));
      end
      if (vecs[v].edv) begin
        chk($sformatf("vec%0d d_resp_data", v), d_resp_data, vecs[v].edd);
        chk($sformatf("vec%0d d_resp_err", v), 32'(d_resp_err), 32'(vecs[v].ede));
      end
    end

    // both ports request every cycle
    do_reset();
    for (int k = 0; k < 4; k++) begin
      logic exp_d;
`ifdef ROM_ARB_RR_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      drive(1'b1, 32'h0, 1'b1, 1'b1, 32'h8, 1'b1);
      chk($sformatf("arb%0d d_req_ready", k), 32'(d_req_ready), 32'(exp_d));
      chk($sformatf("arb%0d i_req_ready", k), 32'(i_req_ready), 32'(!exp_d));
      chk($sformatf("arb%0d rom_addr", k), rom_addr, exp_d ? 32'h8 : 32'h0);
      tick();
      chk($sformatf("arb%0d i_resp_valid", k), 32'(i_resp_valid), 32'(!exp_d));
      chk($sformatf("arb%0d d_resp_valid", k), 32'(d_resp_valid), 32'(exp_d));
      if (exp_d) chk($sformatf("arb%0d d_resp_data", k), d_resp_data, 32'h0e000d13);
      else chk($sformatf("arb%0d i_resp_data", k), i_resp_data, 32'h00001117);
    end

    // stalled I response blocks only I
    do_reset();
    drive(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("stall first i_req_ready", 32'(i_req_ready), 1);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 32'h8, 1'b0, 1'b1, 32'hdc, 1'b1);
      chk($sformatf("stall%0d i_req_ready", k), 32'(i_req_ready), 0);
      chk($sformatf("stall%0d d_req_ready", k), 32'(d_req_ready), 1);
      tick();
      chk($sformatf("stall%0d i_resp_valid", k), 32'(i_resp_valid), 1);
      chk($sformatf("stall%0d i_resp_data", k), i_resp_data, 32'h8e010113);
      chk($sformatf("stall%0d d_resp_valid", k), 32'(d_resp_valid), 1);
      chk($sformatf("stall%0d d_resp_data", k), d_resp_data, 32'h00008067);
    end
    drive(1'b1, 32'h8, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("release i_req_ready", 32'(i_req_ready), 1);
    tick();
    chk("release i_resp_valid", 32'(i_resp_valid), 1);
    chk("release i_resp_data", i_resp_data, 32'h0e000d13);

    // reset with both slots full
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h8, 1'b0);
    chk("fill d_req_ready", 32'(d_req_ready), 1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("full i_resp_valid", 32'(i_resp_valid), 1);
    chk("full d_resp_valid", 32'(d_resp_valid), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst i_resp_valid", 32'(i_resp_valid), 0);
    chk("midrst d_resp_valid", 32'(d_resp_valid), 0);
    chk("midrst d_resp_data", d_resp_data, 0);
    drive(1'b1, 32'hdc, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("postrst i_req_ready", 32'(i_req_ready), 1);
    chk("postrst rom_addr", rom_addr, 32'hdc);
    tick();
    chk("postrst i_resp_valid", 32'(i_resp_valid), 1);
    chk("postrst i_resp_data", i_resp_data, 32'h00008067);

    // streaming fetch
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 32'(4 * k), 1'b1, 1'b0, 32'h0, 1'b1);
      chk($sformatf("stream%0d i_req_ready", k), 32'(i_req_ready), 1);
      tick();
      chk($sformatf("stream%0d i_resp_valid", k), 32'(i_resp_valid), 1);
      chk($sformatf("stream%0d i_resp_data", k), i_resp_data, rom_word(32'(4 * k)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
